// File: rtl/coin_io_ctrl.sv
// Coin-door I/O: synchronizes and debounces coin/service switches, latches coin
// insertion events, and drives two electromechanical coin counters.
module coin_io_ctrl #(
  parameter int DB_TICKS  = 4,
  parameter int ON_TICKS  = 20,
  parameter int OFF_TICKS = 20
) (
  input  logic       clk_main,
  input  logic       nreset,
  input  logic       ce,
  input  logic [3:0] P_coin,
  input  logic [3:0] service,
  input  logic [1:0] cnt_req,
  input  logic [3:0] evt_clr,
  output logic [3:0] coin_db,
  output logic [3:0] service_db,
  output logic [3:0] coin_evt,
  output logic [1:0] coin_counter,
  output logic [1:0] cnt_busy
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LD   = TW'(ON_TICKS);
  localparam logic [TW-1:0] OFF_LD  = TW'(OFF_TICKS);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [2:0]    DB_LAST = 3'(DB_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2} state_t;

  // Bits [3:0] are the coin switches, [7:4] the service switches.
  logic [7:0]      raw_s;
  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      db_q, db_d;
  logic [7:0][2:0] run_q, run_d;
  logic [3:0]      evt_q, evt_d;

  assign raw_s = {service, P_coin};

  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    run_d = run_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        run_d[i] = 3'd0;
      end else if (ce) begin
        if (run_q[i] == DB_LAST) begin
          db_d[i]  = sync2_q[i];
          run_d[i] = 3'd0;
        end else begin
          run_d[i] = run_q[i] + 3'd1;
        end
      end else begin
        run_d[i] = run_q[i];
      end
    end
    // Set wins over a coincident clear so no insertion is ever lost.
    evt_d = (evt_q & ~evt_clr) | (db_q[3:0] & ~db_d[3:0]);
  end

  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      db_q  <= 8'hFF;
      run_q <= '0;
      evt_q <= 4'h0;
    end else begin
      db_q  <= db_d;
      run_q <= run_d;
      evt_q <= evt_d;
    end
  end

  assign coin_db    = db_q[3:0];
  assign service_db = db_q[7:4];
  assign coin_evt   = evt_q;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t        st_q, st_d;
    logic [3:0]    pend_q, pend_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          start_s;

    always_comb begin
      st_d    = st_q;
      tmr_d   = tmr_q;
      start_s = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (pend_q != 4'd0) begin
            st_d    = ST_ON;
            tmr_d   = ON_LD;
            start_s = 1'b1;
          end else begin
            st_d = ST_IDLE;
          end
        end
        ST_ON: begin
          if (ce) begin
            if (tmr_q <= TMR_ONE) begin
              st_d  = ST_OFF;
              tmr_d = OFF_LD;
            end else begin
              tmr_d = tmr_q - TMR_ONE;
            end
          end else begin
            tmr_d = tmr_q;
          end
        end
        ST_OFF: begin
          if (ce) begin
            if (tmr_q > TMR_ONE) begin
              tmr_d = tmr_q - TMR_ONE;
            end else if (pend_q != 4'd0) begin
              st_d    = ST_ON;
              tmr_d   = ON_LD;
              start_s = 1'b1;
            end else begin
              st_d = ST_IDLE;
            end
          end else begin
            tmr_d = tmr_q;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          tmr_d = '0;
        end
      endcase

      // A request coincident with a pulse start cancels the decrement.
      if (start_s && !cnt_req[c]) begin
        pend_d = pend_q - 4'd1;
      end else if (!start_s && cnt_req[c] && (pend_q != 4'd15)) begin
        pend_d = pend_q + 4'd1;
      end else begin
        pend_d = pend_q;
      end

      out_d  = (st_d == ST_ON);
      busy_d = (st_d != ST_IDLE) || (pend_d != 4'd0);
    end

    always_ff @(posedge clk_main or negedge nreset) begin
      if (!nreset) begin
        st_q   <= ST_IDLE;
        tmr_q  <= '0;
        pend_q <= 4'd0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        tmr_q  <= tmr_d;
        pend_q <= pend_d;
        out_q  <= out_d;
        busy_q <= busy_d;
      end
    end

    assign coin_counter[c] = out_q;
    assign cnt_busy[c]     = busy_q;
  end

endmodule

// File: tb/tb_coin_io_ctrl.sv
// Scoreboard bench for coin_io_ctrl: stimulus pushes expected debounce, event and
// counter-pulse responses; an independent monitor pops and compares them.
module tb_coin_io_ctrl;

  localparam int DB  = 4;
  localparam int ON  = 20;
  localparam int OFF = 20;

  logic       clk_main = 1'b0;
  logic       nreset   = 1'b0;
  logic       ce       = 1'b0;
  logic [3:0] P_coin   = 4'hF;
  logic [3:0] service  = 4'hF;
  logic [1:0] cnt_req  = 2'b00;
  logic [3:0] evt_clr  = 4'h0;
  logic [3:0] coin_db, service_db, coin_evt;
  logic [1:0] coin_counter, cnt_busy;

  int vectors = 0;
  int errs    = 0;
  int q_db[$];      // idx*2 + new level
  int q_evt[$];     // coin index
  int q_on[2][$];   // expected high time in ce ticks, one entry per pulse

  coin_io_ctrl #(.DB_TICKS(DB), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
    .clk_main(clk_main), .nreset(nreset), .ce(ce),
    .P_coin(P_coin), .service(service), .cnt_req(cnt_req), .evt_clr(evt_clr),
    .coin_db(coin_db), .service_db(service_db), .coin_evt(coin_evt),
    .coin_counter(coin_counter), .cnt_busy(cnt_busy)
  );

  always #5 clk_main = ~clk_main;

  // ce is high for one clock out of every four.
  initial begin : ce_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk_main);
      #1;
      div = (div + 1) % 4;
      ce  = (div == 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int idx, input logic v);
    if (idx < 4) P_coin[idx] = v;
    else         service[idx-4] = v;
  endtask

  // Returns just after the clock edge that consumed the n-th following ce.
  task automatic wait_ce(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_main);
      while (!ce) @(negedge clk_main);
      @(posedge clk_main);
      #2;
    end
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    @(negedge clk_main);
    evt_clr = m;
    @(negedge clk_main);
    evt_clr = 4'h0;
  endtask

  task automatic burst(input int n0, input int n1);
    int cyc;
    for (int k = 0; k < ((n0 > 16) ? 16 : n0); k++) q_on[0].push_back(ON);
    for (int k = 0; k < ((n1 > 16) ? 16 : n1); k++) q_on[1].push_back(ON);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_main);
      cnt_req = {(k < n1), (k < n0)};
    end
    @(negedge clk_main);
    cnt_req = 2'b00;
    cyc = 0;
    while (cnt_busy != 2'b00 && cyc < 5000) begin
      @(negedge clk_main);
      cyc++;
    end
    check("burst_idle", int'(cnt_busy), 0);
    check("burst_left0", q_on[0].size(), 0);
    check("burst_left1", q_on[1].size(), 0);
  endtask

  initial begin : monitor
    logic [7:0] cur_db, prev_db;
    logic [3:0] prev_evt;
    logic [1:0] prev_cc, prev_busy;
    int hi[2], gap[2];
    bit in_gap[2];
    forever begin
      @(negedge clk_main);
      cur_db = {service_db, coin_db};
      if (!nreset) begin
        for (int c = 0; c < 2; c++) begin
          hi[c] = 0; gap[c] = 0; in_gap[c] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (cur_db[i] != prev_db[i]) begin
            if (q_db.size() == 0) check("db_unexpected", i*2 + int'(cur_db[i]), -1);
            else                  check("db_event", i*2 + int'(cur_db[i]), q_db.pop_front());
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (coin_evt[i] && !prev_evt[i]) begin
            if (q_evt.size() == 0) check("evt_unexpected", i, -1);
            else                   check("evt_event", i, q_evt.pop_front());
          end
        end
        for (int c = 0; c < 2; c++) begin
          if (coin_counter[c] && !prev_cc[c]) begin
            if (in_gap[c]) check("off_ticks", gap[c], OFF);
            hi[c] = 0;
            in_gap[c] = 1'b0;
          end
          if (!coin_counter[c] && prev_cc[c]) begin
            if (q_on[c].size() == 0) check("pulse_unexpected", hi[c], -1);
            else                     check("on_ticks", hi[c], q_on[c].pop_front());
            gap[c] = 0;
            in_gap[c] = 1'b1;
          end
          if (!cnt_busy[c] && prev_busy[c] && in_gap[c]) begin
            check("busy_fall_ticks", gap[c], OFF);
            in_gap[c] = 1'b0;
          end
          if (ce) begin
            if (coin_counter[c]) hi[c]++;
            else if (in_gap[c]) gap[c]++;
          end
        end
      end
      prev_db   = cur_db;
      prev_evt  = coin_evt;
      prev_cc   = coin_counter;
      prev_busy = cnt_busy;
    end
  end

  initial begin : stim
    int lens[6];
    int idx, len, cyc;
    logic [3:0] m;
    bit seen;
    lens = '{1, 2, 3, 6, 7, 8};

    repeat (3) @(posedge clk_main);
    #2;
    check("rst_coin_db", int'(coin_db), 15);
    check("rst_service_db", int'(service_db), 15);
    check("rst_evt", int'(coin_evt), 0);
    check("rst_counter", int'(coin_counter), 0);
    check("rst_busy", int'(cnt_busy), 0);
    nreset = 1'b1;
    wait_ce(2);

    // Coin 0 inserted: falls on the 4th ce sample, event latched, then cleared.
    q_db.push_back(0);
    q_evt.push_back(0);
    set_in(0, 1'b0);
    wait_ce(DB - 1);
    check("db0_early", int'(coin_db[0]), 1);
    wait_ce(1);
    check("db0_fall", int'(coin_db[0]), 0);
    check("evt0_set", int'(coin_evt), 1);
    wait_ce(6);
    pulse_clr(4'b0001);
    check("evt0_clr", int'(coin_evt), 0);
    q_db.push_back(1);
    set_in(0, 1'b1);
    wait_ce(8);

    // Short glitch on coin 2 is rejected.
    set_in(2, 1'b0);
    wait_ce(3);
    set_in(2, 1'b1);
    wait_ce(8);
    check("glitch_db", int'(coin_db), 15);
    check("glitch_evt", int'(coin_evt), 0);

    // Clear strobed in the very cycle coin 1 falls: set wins.
    q_db.push_back(2);
    q_evt.push_back(1);
    set_in(1, 1'b0);
    wait_ce(DB - 1);
    @(negedge clk_main);
    while (!ce) @(negedge clk_main);
    evt_clr = 4'b0010;
    @(posedge clk_main);
    #2;
    evt_clr = 4'h0;
    check("coinc_db1", int'(coin_db[1]), 0);
    check("coinc_evt1", int'(coin_evt[1]), 1);
    pulse_clr(4'b0010);
    q_db.push_back(3);
    set_in(1, 1'b1);
    wait_ce(8);

    // Random presses and glitches on all eight switches.
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(7, 0);
      len = lens[$urandom_range(5, 0)];
      if (len >= 6) begin
        q_db.push_back(idx*2);
        if (idx < 4) q_evt.push_back(idx);
      end
      set_in(idx, 1'b0);
      wait_ce(len);
      if (len >= 6) begin
        if (idx < 4) begin
          m = 4'b0001 << idx;
          pulse_clr(m);
          check("rnd_evt_clr", int'(coin_evt), 0);
        end
        q_db.push_back(idx*2 + 1);
      end
      set_in(idx, 1'b1);
      wait_ce(8);
      check("rnd_db_settled", int'({service_db, coin_db}), 255);
    end

    // Counter bursts: three pulses, saturation, and random counts.
    burst(3, 0);
    burst(0, 20);
    for (int r = 0; r < 2; r++) burst($urandom_range(20, 0), $urandom_range(20, 0));

    // Reset during channel 0 ON with two counts pending.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_main);
      cnt_req = 2'b01;
    end
    @(negedge clk_main);
    cnt_req = 2'b00;
    cyc = 0;
    while (!coin_counter[0] && cyc < 50) begin
      @(negedge clk_main);
      cyc++;
    end
    check("pre_rst_on", int'(coin_counter[0]), 1);
    wait_ce(5);
    nreset = 1'b0;
    #1;
    check("midrst_counter", int'(coin_counter), 0);
    check("midrst_busy", int'(cnt_busy), 0);
    repeat (3) @(negedge clk_main);
    nreset = 1'b1;
    seen = 1'b0;
    repeat (700) begin
      @(negedge clk_main);
      if (coin_counter != 2'b00 || cnt_busy != 2'b00) seen = 1'b1;
    end
    check("post_rst_quiet", int'(seen), 0);

    // Coin 3 held low across reset release yields exactly one event.
    nreset = 1'b0;
    set_in(3, 1'b0);
    repeat (3) @(negedge clk_main);
    q_db.push_back(6);
    q_evt.push_back(3);
    nreset = 1'b1;
    wait_ce(DB + 3);
    check("rel_db3", int'(coin_db[3]), 0);
    check("rel_evt", int'(coin_evt), 8);
    pulse_clr(4'b1000);
    q_db.push_back(7);
    set_in(3, 1'b1);
    wait_ce(8);

    check("left_db", q_db.size(), 0);
    check("left_evt", q_evt.size(), 0);
    check("left_on0", q_on[0].size(), 0);
    check("left_on1", q_on[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
